// File: rtl/bird_datapath.sv
// bird_datapath: bird position integrator and sprite renderer.
//
// Latches the controller's state code into a motion mode and moves the
// bird's top row once per frame tick. It also registers the ceiling flag
// and the ground-contact signal. Whenever the stored position differs from
// the sprite last drawn, it streams pixels onto the VGA plot bus.
//
// Optional feature macro: BIRD_ERASE_EN
//   defined   : the old sprite is erased in BG_COLOUR before the new one is
//               drawn (render = 2*W*H cycles).
//   undefined : only the new sprite is drawn, so trails remain
//               (render = W*H cycles).
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous, active-high
//   state   in   [3:0] controller code: 0 START, 1 RAISING, 2 FALLING,
//                3 STOP, 4 DRAW
//   flag    out  bird at or above the ceiling row (registered)
//   ground  out  bird on the floor row (registered)
//   bird_y  out  [6:0] current sprite top row
//   x       out  [7:0] pixel column
//   y       out  [6:0] pixel row
//   colour  out  [2:0] pixel colour
//   plot    out  pixel write strobe
//   busy    out  render in progress (same as plot)

module bird_datapath #(
   parameter int unsigned BIRD_X      = 20,
   parameter int unsigned BIRD_W      = 4,
   parameter int unsigned BIRD_H      = 4,
   parameter int unsigned START_Y     = 60,
   parameter int unsigned CEILING_Y   = 8,
   parameter int unsigned FLOOR_Y     = 116,
   parameter int unsigned RISE_STEP   = 2,
   parameter int unsigned FALL_STEP   = 1,
   parameter int unsigned TICK_DIV    = 833333,
   parameter logic [2:0]  BIRD_COLOUR = 3'b110,
   parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] state,
   output logic       flag,
   output logic       ground,
   output logic [6:0] bird_y,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned ColW = (BIRD_W > 1) ? $clog2(BIRD_W) : 1;
   localparam int unsigned RowW = (BIRD_H > 1) ? $clog2(BIRD_H) : 1;

   localparam logic [6:0] StartY  = 7'(START_Y);
   localparam logic       FlagRst = (START_Y <= CEILING_Y);

   // Render FSM encoding
   localparam logic [1:0] StInit  = 2'd0;
   localparam logic [1:0] StIdle  = 2'd1;
   localparam logic [1:0] StErase = 2'd2;
   localparam logic [1:0] StDraw  = 2'd3;

   // ------------------------------------------------------------------
   // Motion: mode latch, frame tick, position integrator
   // ------------------------------------------------------------------
   logic [3:0]      mode_q;
   logic [CntW-1:0] count_q, count_d;
   logic            tick;
   logic [6:0]      bird_y_q, bird_y_d;
   logic            flag_q, flag_d;
   logic            ground_q, ground_d;

   logic [7:0] y_ext, y_sum, y_dif, y_nxt;

   assign tick = (count_q == CntW'(TICK_DIV - 1));

   always_comb begin
      count_d = tick ? '0 : count_q + CntW'(1);
   end

   // 8-bit arithmetic so the rise can detect underflow and the fall can
   // clamp at the floor before the 7-bit store.
   always_comb begin
      y_ext = {1'b0, bird_y_q};
      y_sum = y_ext + 8'(FALL_STEP);
      y_dif = y_ext - 8'(RISE_STEP);
      y_nxt = y_ext;
      case (mode_q)
         4'd0: y_nxt = {1'b0, StartY};
         4'd1: y_nxt = (y_ext < 8'(RISE_STEP)) ? 8'd0 : y_dif;
         4'd2: y_nxt = (y_sum > 8'(FLOOR_Y)) ? 8'(FLOOR_Y) : y_sum;
         default: y_nxt = y_ext;
      endcase
      bird_y_d = tick ? y_nxt[6:0] : bird_y_q;
      flag_d   = ({1'b0, bird_y_d} <= 8'(CEILING_Y));
      ground_d = ({1'b0, bird_y_d} >= 8'(FLOOR_Y));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q   <= 4'd0;
         count_q  <= '0;
         bird_y_q <= StartY;
         flag_q   <= FlagRst;
         ground_q <= 1'b0;
      end else begin
         // DRAW cycles leave the motion mode untouched
         if (state != 4'd4) begin
            mode_q <= state;
         end
         count_q  <= count_d;
         bird_y_q <= bird_y_d;
         flag_q   <= flag_d;
         ground_q <= ground_d;
      end
   end

   assign bird_y = bird_y_q;
   assign flag   = flag_q;
   assign ground = ground_q;

   // ------------------------------------------------------------------
   // Renderer
   // ------------------------------------------------------------------
   logic [1:0]      st_q, st_d;
   logic [ColW-1:0] col_q, col_d, col_nxt;
   logic [RowW-1:0] row_q, row_d, row_nxt;
   logic [6:0]      drawn_y_q, drawn_y_d;
   logic [6:0]      target_y_q, target_y_d;
   logic            pix_last;

   logic [7:0] pix_x_q, pix_x_d;
   logic [6:0] pix_y_q, pix_y_d;
   logic [2:0] colour_q, colour_d;
   logic       plot_q, plot_d;
   logic [6:0] base_d;

   // Column is the inner counter, row the outer.
   always_comb begin
      pix_last = (col_q == ColW'(BIRD_W - 1)) && (row_q == RowW'(BIRD_H - 1));
      if (col_q == ColW'(BIRD_W - 1)) begin
         col_nxt = '0;
         row_nxt = row_q + RowW'(1);
      end else begin
         col_nxt = col_q + ColW'(1);
         row_nxt = row_q;
      end
   end

   always_comb begin
      st_d       = st_q;
      col_d      = col_q;
      row_d      = row_q;
      drawn_y_d  = drawn_y_q;
      target_y_d = target_y_q;
      unique case (st_q)
         StInit: begin
            if (pix_last) begin
               st_d  = StIdle;
               col_d = '0;
               row_d = '0;
            end else begin
               col_d = col_nxt;
               row_d = row_nxt;
            end
         end
         StIdle: begin
            // Snapshot the target so a tick mid-render cannot move it
            if (bird_y_q != drawn_y_q) begin
               target_y_d = bird_y_q;
`ifdef BIRD_ERASE_EN
               st_d = StErase;
`else
               st_d = StDraw;
`endif
            end
         end
         StErase: begin
            if (pix_last) begin
               st_d  = StDraw;
               col_d = '0;
               row_d = '0;
            end else begin
               col_d = col_nxt;
               row_d = row_nxt;
            end
         end
         StDraw: begin
            if (pix_last) begin
               st_d      = StIdle;
               col_d     = '0;
               row_d     = '0;
               drawn_y_d = target_y_q;
            end else begin
               col_d = col_nxt;
               row_d = row_nxt;
            end
         end
      endcase
   end

   // Pixel bus is decoded from next-state so it is registered alongside it.
   always_comb begin
      case (st_d)
         StInit:  base_d = StartY;
         StErase: base_d = drawn_y_d;
         StDraw:  base_d = target_y_d;
         default: base_d = drawn_y_d;
      endcase
      pix_x_d  = 8'(BIRD_X) + 8'(col_d);
      pix_y_d  = base_d + 7'(row_d);
      colour_d = (st_d == StErase) ? BG_COLOUR : BIRD_COLOUR;
      plot_d   = (st_d != StIdle);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q       <= StInit;
         col_q      <= '0;
         row_q      <= '0;
         drawn_y_q  <= StartY;
         target_y_q <= StartY;
         pix_x_q    <= 8'(BIRD_X);
         pix_y_q    <= StartY;
         colour_q   <= BIRD_COLOUR;
         plot_q     <= 1'b1;
      end else begin
         st_q       <= st_d;
         col_q      <= col_d;
         row_q      <= row_d;
         drawn_y_q  <= drawn_y_d;
         target_y_q <= target_y_d;
         pix_x_q    <= pix_x_d;
         pix_y_q    <= pix_y_d;
         colour_q   <= colour_d;
         plot_q     <= plot_d;
      end
   end

   assign x      = pix_x_q;
   assign y      = pix_y_q;
   assign colour = colour_q;
   assign plot   = plot_q;
   assign busy   = plot_q;

endmodule
